ether_tx_scheduler: RTL
=======================

Name: ether_tx_scheduler

Overview:
Frame-level scheduler that shares the single RMII transmit dibit path between two frame sources. It grants one source per frame using round-robin order, and inserts the 7-byte preamble and SFD ahead of each frame. It enforces the minimum inter-packet gap after each frame and terminates frames on source underrun. It sits between the two frame generators (which deliver payload dibits already in wire order) and the RMII TX pins.

Parameters:
PREAMBLE_DIBITS, 32, preamble plus SFD length in dibits; the last dibit is the SFD marker 2'b11, all others are 2'b01.
IPG_DIBITS, 48, minimum idle dibits between frames (12 bytes); legal range 2..255.

Ports:
clk  in  1  system clock (RMII reference, 50 MHz)
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  source 0 has a dibit available
req0_data  in  2  source 0 dibit, wire order
req0_last  in  1  source 0 dibit is the final dibit of the frame
req0_ready  out  1  source 0 dibit accepted this cycle when valid
req1_valid  in  1  source 1 has a dibit available
req1_data  in  2  source 1 dibit, wire order
req1_last  in  1  source 1 dibit is the final dibit of the frame
req1_ready  out  1  source 1 dibit accepted this cycle when valid
axiod  out  2  transmit dibit, registered
axiov  out  1  transmit enable, registered
busy  out  1  high in any state other than IDLE
underrun  out  1  one-cycle pulse when the granted source drops valid mid-frame, registered
grant  out  1  index of the current or most recent granted source

Behaviour:
- Reset (async, rst=1): state=IDLE; axiod=0, axiov=0, underrun=0, counter=0; grant=1, so source 0 wins the first tie. The reset takes effect immediately, including mid-frame. No partial frame resumes after reset.
- States: IDLE, PREAMBLE, DATA, GAP. The 8-bit counter is shared between PREAMBLE and GAP.
- IDLE: axiov<=0, axiod<=0.
  - If any valid is high, latch grant:
    - Only one source valid: grant goes to that source.
    - Both valid: grant goes to the source not granted last (round-robin, whole-frame granularity).
  - Also set axiod<=2'b01, axiov<=1, counter<=1, state<=PREAMBLE.
- PREAMBLE: axiov<=1.
  - axiod<=2'b11 when counter==PREAMBLE_DIBITS-1, else 2'b01.
  - At that count, state<=DATA; otherwise counter++.
  - reqN_ready stays 0 throughout.
- DATA: ready is combinational, granted_ready = (state==DATA). The non-granted ready is 0.
  - granted valid=1: accept the beat; axiod<=data, axiov<=1. If last=1, state<=GAP and counter<=0.
  - granted valid=0: underrun<=1 for one cycle, axiov<=0, axiod<=0, state<=GAP, counter<=0. The source must restart the frame later; its remaining dibits are treated as a new frame request.
- GAP: axiov<=0, axiod<=0; counter++. When counter==IPG_DIBITS-1, state<=IDLE.
- Timing: request seen in IDLE at cycle t.
  - Preamble dibits appear on axiod at t+1..t+32.
  - The first payload dibit is accepted at t+32 and is visible at t+33, so there are no bubbles between SFD and payload.
  - Payload latency is 1 cycle from acceptance to axiod.
  - A last beat accepted at cycle d puts the final dibit on the wire at d+1. axiov is low for at least IPG_DIBITS cycles (d+2..d+IPG_DIBITS+1). The earliest next preamble dibit is at d+IPG_DIBITS+2.
- Requests arriving during PREAMBLE, DATA or GAP from the non-granted source wait; they are not dropped.
- Payload length is unbounded; no length or CRC checking in this block.

Decomposition:
- Shared ethernet package: PREAMBLE_DIBIT (2'b01), SFD_LAST_DIBIT (2'b11), default preamble/IPG lengths, and the scheduler state encoding (2-bit, IDLE=0, PREAMBLE=1, DATA=2, GAP=3).
- One natural sub-module: ether_tx_rr_pick. It is combinational; it takes the two valids and the last grant and returns the next grant and a hit flag. It is reusable when the source count grows.

Test Plan:
- Single frame: req0 presents 8 dibits (3,2,1,0,3,2,1,0), last on the 8th. Required: axiov high for 40 cycles; 31×01, then 11, then 3,2,1,0,3,2,1,0; grant=0; underrun never pulses.
- Contention: req0 and req1 both valid in IDLE after reset. Required: source 0 is served first, then source 1 after exactly 48 idle cycles; grant sequence 0,1. With both continuously requesting, the sequence alternates 0,1,0,1.
- Minimum IPG: req0 re-asserts valid the cycle after its last beat. Required: axiov low for exactly IPG_DIBITS=48 cycles, then the preamble starts.
- Underrun: req1 drops valid after 3 payload dibits. Required: underrun pulses once on the following cycle, axiov falls that same cycle, then 48 idle cycles, then IDLE (busy=0).
- Async reset mid-DATA: assert rst between clock edges. Required: axiov=0, axiod=0, busy=0 immediately, without waiting for a clock edge; after release with req1 valid, a fresh preamble starts and grant=1.
- Single requester streaming: only req1 valid, with back-to-back frames. Required: grant stays 1 for every frame; req0_ready is never high.

Source files
------------

// File: rtl/ether_tx_scheduler_pkg.sv
// Shared Ethernet TX definitions: line-coding constants, default frame
// timing and the scheduler state encoding.
package ether_tx_scheduler_pkg;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;

  localparam int DEFAULT_PREAMBLE_DIBITS = 32;
  localparam int DEFAULT_IPG_DIBITS      = 48;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GAP      = 2'd3
  } tx_state_t;

  // Preamble dibit for a given position; the final position carries the SFD.
  function automatic logic [1:0] preamble_dibit(input logic [7:0] count,
                                                input logic [7:0] last_count);
    logic [1:0] dibit;
    if (count == last_count) begin
      dibit = SFD_LAST_DIBIT;
    end else begin
      dibit = PREAMBLE_DIBIT;
    end
    return dibit;
  endfunction

endpackage

// File: rtl/ether_tx_rr_pick.sv
// Two-way round-robin picker: chooses the next source from the current
// requests and the previously granted source.
module ether_tx_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic next_grant,
  output logic hit
);

  // Prefer the source not served last when both request.
  always_comb begin
    hit        = valid0 | valid1;
    next_grant = last_grant;
    if (valid0 && valid1) begin
      next_grant = ~last_grant;
    end else if (valid1) begin
      next_grant = 1'b1;
    end else if (valid0) begin
      next_grant = 1'b0;
    end else begin
      next_grant = last_grant;
    end
  end

endmodule

// File: rtl/ether_tx_scheduler.sv
// Shares the RMII TX dibit path between two frame sources. Each frame gets
// a preamble/SFD prefix, frames are separated by the minimum inter-packet
// gap, and a source that stalls mid-frame has its frame cut short.
module ether_tx_scheduler
  import ether_tx_scheduler_pkg::*;
#(
  parameter int PREAMBLE_DIBITS = DEFAULT_PREAMBLE_DIBITS,
  parameter int IPG_DIBITS      = DEFAULT_IPG_DIBITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [1:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [1:0] axiod,
  output logic       axiov,
  output logic       busy,
  output logic       underrun,
  output logic       grant
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_DIBITS - 1);
  localparam logic [7:0] GAP_LAST = 8'(IPG_DIBITS - 1);

  tx_state_t  state;
  logic [7:0] counter;

  logic       sel_valid;
  logic [1:0] sel_data;
  logic       sel_last;
  logic       pick_grant;
  logic       pick_hit;

  // Route the granted source's beat into the datapath.
  always_comb begin
    if (grant) begin
      sel_valid = req1_valid;
      sel_data  = req1_data;
      sel_last  = req1_last;
    end else begin
      sel_valid = req0_valid;
      sel_data  = req0_data;
      sel_last  = req0_last;
    end
  end

  assign req0_ready = (state == ST_DATA) && !grant;
  assign req1_ready = (state == ST_DATA) && grant;
  assign busy       = (state != ST_IDLE);

  ether_tx_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (grant),
    .next_grant (pick_grant),
    .hit        (pick_hit)
  );

  // Frame sequencer: arbitration, preamble, payload, inter-packet gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      counter  <= 8'd0;
      grant    <= 1'b1;
      axiod    <= 2'b00;
      axiov    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          axiov   <= 1'b0;
          axiod   <= 2'b00;
          counter <= 8'd0;
          if (pick_hit) begin
            grant   <= pick_grant;
            axiod   <= PREAMBLE_DIBIT;
            axiov   <= 1'b1;
            counter <= 8'd1;
            state   <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          axiov <= 1'b1;
          axiod <= preamble_dibit(counter, PRE_LAST);
          if (counter == PRE_LAST) begin
            state <= ST_DATA;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        ST_DATA: begin
          if (sel_valid) begin
            axiod <= sel_data;
            axiov <= 1'b1;
            if (sel_last) begin
              state   <= ST_GAP;
              counter <= 8'd0;
            end
          end else begin
            // Source stalled mid-frame: cut the frame and go to the gap.
            underrun <= 1'b1;
            axiov    <= 1'b0;
            axiod    <= 2'b00;
            state    <= ST_GAP;
            counter  <= 8'd0;
          end
        end
        ST_GAP: begin
          axiov   <= 1'b0;
          axiod   <= 2'b00;
          counter <= counter + 8'd1;
          if (counter == GAP_LAST) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          counter <= 8'd0;
          axiov   <= 1'b0;
          axiod   <= 2'b00;
        end
      endcase
    end
  end

endmodule
